reloj_alarm: RTL and testbench
==============================

RELOJ_ALARM -- requirements
Module: reloj_alarm

Interface
REQ-001 SHALL have parameter RING_SECONDS, default 60, seconds the alarm rings before auto-stop (1..255).
REQ-002 SHALL have parameter SNOOZE_MIN, default 5, snooze delay in minutes (1..59).
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port tick  in  1  one-cycle pulse per second from the upstream interval timer.
REQ-006 SHALL have port address  in  3  Avalon-MM word address.
REQ-007 SHALL have port chipselect  in  1  slave select.
REQ-008 SHALL have port write_n  in  1  active-low write.
REQ-009 SHALL have port writedata  in  16  write data.
REQ-010 SHALL have port readdata  out  16  registered read data.
REQ-011 SHALL have port irq  out  1  alarm interrupt.
REQ-012 SHALL have port buzzer  out  1  high while ringing.

Function
REQ-013 SHALL keep binary time: sec 0..59, min 0..59, hour 0..23; each tick increments sec, with carry into min and hour; 23:59:59 + tick -> 00:00:00.
REQ-014 SHALL map registers: 0 sec, 1 min, 2 hour, 3 alarm_min, 4 alarm_hour, 5 control {bit1 irq_en, bit0 alarm_en}, 6 status {bit2 event, bit1 snoozed, bit0 ringing}; unused bits and address 7 read 0.
REQ-015 SHALL update readdata one cycle after any cycle with a valid address (read latency 1, no wait states).
REQ-016 SHALL ignore writes to sec/min/alarm_min with value >59 and to hour/alarm_hour with value >23 (register unchanged).
REQ-017 SHALL give a time-register write priority over tick in the same cycle; that tick is dropped entirely (no carry).
REQ-018 SHALL implement FSM IDLE, RINGING, SNOOZED; buzzer = (state == RINGING).
REQ-019 SHALL raise a match when a tick moves time to sec==0 with hour:min equal to the target; target = alarm registers in IDLE, snooze target in SNOOZED.
REQ-020 SHALL transition IDLE->RINGING and SNOOZED->RINGING on match when alarm_en=1, setting event and loading the ring counter with RING_SECONDS.
REQ-021 SHALL decrement the ring counter per tick in RINGING; on reaching 0, return to IDLE.
REQ-022 SHALL handle status write (address 6): bit0 dismiss -> IDLE; bit1 snooze (RINGING only) -> SNOOZED with snooze target = current hour:min + SNOOZE_MIN, wrapping mod 24h; bit2 clears event.
REQ-023 SHALL give dismiss priority over snooze in the same write, and event set over event clear in the same cycle.
REQ-024 SHALL force state to IDLE on the cycle after alarm_en is written 0, from any state.
REQ-025 SHALL drive irq = event && irq_en, combinationally from registers.

Reset
REQ-026 SHALL on reset: time 00:00:00, alarm 00:00, control 0, event 0, state IDLE, ring counter 0, readdata 0, irq 0, buzzer 0, regardless of current state.

Structure
REQ-027 SHALL place the FSM state enum, register address constants, and limits 59/23 in shared package reloj_alarm_pkg.
REQ-028 SHALL implement the sec/min/hour cascade with load ports as sub-module reloj_time_counter.

Verification
REQ-029 SHALL cover rollover: set 23:59:59, one tick -> time 00:00:00; sec reads 0 two cycles after read issue.
REQ-030 SHALL cover alarm: alarm 07:30, time 07:29:59, alarm_en=1, irq_en=1, tick -> buzzer=1, irq=1 next cycle; 60 further ticks -> buzzer=0.
REQ-031 SHALL cover snooze: ringing at 07:30, write status 0x2 -> buzzer=0, status reads 0x6; time reaches 07:35:00 -> buzzer=1.
REQ-032 SHALL cover collisions: write sec=10 in the same cycle as tick -> sec=10; status write 0x3 while ringing -> IDLE, not SNOOZED.
REQ-033 SHALL cover illegal writes: write min=60, hour=24 -> both unchanged; write control 0 while ringing -> buzzer=0 within one cycle.
REQ-034 SHALL cover reset asserted while RINGING at 12:00:05 -> all outputs 0 immediately, time 00:00:00 after release.

Source files
------------

// File: rtl/reloj_alarm_pkg.sv
// Shared types and constants for the alarm clock: FSM states, register map,
// time limits and the minute-offset helper used for snooze targets.
package reloj_alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } alarm_state_t;

  localparam logic [2:0] ADDR_SEC        = 3'd0;
  localparam logic [2:0] ADDR_MIN        = 3'd1;
  localparam logic [2:0] ADDR_HOUR       = 3'd2;
  localparam logic [2:0] ADDR_ALARM_MIN  = 3'd3;
  localparam logic [2:0] ADDR_ALARM_HOUR = 3'd4;
  localparam logic [2:0] ADDR_CONTROL    = 3'd5;
  localparam logic [2:0] ADDR_STATUS     = 3'd6;

  localparam logic [5:0] SEC_LIMIT  = 6'd59;
  localparam logic [5:0] MIN_LIMIT  = 6'd59;
  localparam logic [4:0] HOUR_LIMIT = 5'd23;

  // Adds delta (< 60) minutes to hour:min, wrapping across midnight; returns {hour, min}.
  function automatic logic [10:0] add_minutes(input logic [4:0] hour,
                                              input logic [5:0] min,
                                              input logic [5:0] delta);
    logic [6:0] m_sum;
    logic [4:0] h_out;
    m_sum = {1'b0, min} + {1'b0, delta};
    if (m_sum > 7'd59) begin
      m_sum = m_sum - 7'd60;
      h_out = (hour == HOUR_LIMIT) ? 5'd0 : hour + 5'd1;
    end else begin
      h_out = hour;
    end
    return {h_out, m_sum[5:0]};
  endfunction

endpackage

// File: rtl/reloj_time_counter.sv
// Binary sec/min/hour cascade with per-field load ports. Exposes the
// post-carry minute/hour so the alarm compare can act in the same cycle.
module reloj_time_counter
  import reloj_alarm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load_sec,
  input  logic       load_min,
  input  logic       load_hour,
  input  logic [5:0] load_value,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       minute_carry,
  output logic [5:0] next_min,
  output logic [4:0] next_hour
);

  logic any_load_s;

  // Carry detection and the time the minute carry would produce.
  always_comb begin
    any_load_s   = load_sec | load_min | load_hour;
    minute_carry = tick && (sec == SEC_LIMIT);
    if (min == MIN_LIMIT) begin
      next_min  = 6'd0;
      next_hour = (hour == HOUR_LIMIT) ? 5'd0 : hour + 5'd1;
    end else begin
      next_min  = min + 6'd1;
      next_hour = hour;
    end
  end

  // Time registers: a load in a cycle swallows that cycle's tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec  <= 6'd0;
      min  <= 6'd0;
      hour <= 5'd0;
    end else if (any_load_s) begin
      if (load_sec)  sec  <= load_value;
      if (load_min)  min  <= load_value;
      if (load_hour) hour <= load_value[4:0];
    end else if (tick) begin
      if (minute_carry) begin
        sec  <= 6'd0;
        min  <= next_min;
        hour <= next_hour;
      end else begin
        sec <= sec + 6'd1;
      end
    end
  end

endmodule

// File: rtl/reloj_alarm.sv
// Avalon-MM alarm clock: time keeping, alarm/snooze FSM, ring timeout,
// interrupt and buzzer outputs.
module reloj_alarm
  import reloj_alarm_pkg::*;
#(
  parameter int RING_SECONDS = 60,
  parameter int SNOOZE_MIN   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        buzzer
);

  alarm_state_t state_r, state_nx_s;

  logic       wr_s, min_ok_s, hour_ok_s;
  logic       ld_sec_s, ld_min_s, ld_hour_s, tick_eff_s;
  logic       ctrl_wr_s, stat_wr_s, match_s, ring_load_s, snooze_s;
  logic [5:0] sec_s, min_s, next_min_s, tgt_min_s;
  logic [4:0] hour_s, next_hour_s, tgt_hour_s;
  logic       minute_carry_s;
  logic [5:0] alarm_min_r, snz_min_r;
  logic [4:0] alarm_hour_r, snz_hour_r;
  logic [1:0] control_r;
  logic       event_r;
  logic [7:0] ring_cnt_r;
  logic [15:0] rd_mux_s;

  // Write decode; an accepted time write drops the concurrent tick.
  always_comb begin
    wr_s       = chipselect && !write_n;
    min_ok_s   = writedata <= 16'd59;
    hour_ok_s  = writedata <= 16'd23;
    ld_sec_s   = wr_s && (address == ADDR_SEC)  && min_ok_s;
    ld_min_s   = wr_s && (address == ADDR_MIN)  && min_ok_s;
    ld_hour_s  = wr_s && (address == ADDR_HOUR) && hour_ok_s;
    tick_eff_s = tick && !(ld_sec_s || ld_min_s || ld_hour_s);
    ctrl_wr_s  = wr_s && (address == ADDR_CONTROL);
    stat_wr_s  = wr_s && (address == ADDR_STATUS);
  end

  reloj_time_counter u_time (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick_eff_s),
    .load_sec     (ld_sec_s),
    .load_min     (ld_min_s),
    .load_hour    (ld_hour_s),
    .load_value   (writedata[5:0]),
    .sec          (sec_s),
    .min          (min_s),
    .hour         (hour_s),
    .minute_carry (minute_carry_s),
    .next_min     (next_min_s),
    .next_hour    (next_hour_s)
  );

  // Match target and compare against the time the tick is about to produce.
  always_comb begin
    if (state_r == ST_SNOOZED) begin
      tgt_min_s  = snz_min_r;
      tgt_hour_s = snz_hour_r;
    end else begin
      tgt_min_s  = alarm_min_r;
      tgt_hour_s = alarm_hour_r;
    end
    match_s = minute_carry_s && control_r[0] &&
              ((state_r == ST_IDLE) || (state_r == ST_SNOOZED)) &&
              (next_min_s == tgt_min_s) && (next_hour_s == tgt_hour_s);
  end

  // Next-state logic, highest priority first: disable, dismiss, snooze, match, timeout.
  always_comb begin
    state_nx_s  = state_r;
    ring_load_s = 1'b0;
    snooze_s    = 1'b0;
    if (ctrl_wr_s && !writedata[0]) begin
      state_nx_s = ST_IDLE;
    end else if (stat_wr_s && writedata[0]) begin
      state_nx_s = ST_IDLE;
    end else if (stat_wr_s && writedata[1] && (state_r == ST_RINGING)) begin
      state_nx_s = ST_SNOOZED;
      snooze_s   = 1'b1;
    end else if (match_s) begin
      state_nx_s  = ST_RINGING;
      ring_load_s = 1'b1;
    end else if ((state_r == ST_RINGING) && tick_eff_s && (ring_cnt_r <= 8'd1)) begin
      state_nx_s = ST_IDLE;
    end else begin
      state_nx_s = state_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nx_s;
  end

  // Ring counter: loaded on entry, counts ticks down, idles at zero elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          ring_cnt_r <= 8'd0;
    else if (ring_load_s)               ring_cnt_r <= 8'(RING_SECONDS);
    else if (state_nx_s != ST_RINGING)  ring_cnt_r <= 8'd0;
    else if (tick_eff_s && (ring_cnt_r != 8'd0)) ring_cnt_r <= ring_cnt_r - 8'd1;
    else                                ring_cnt_r <= ring_cnt_r;
  end

  // Event flag: a new ring wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          event_r <= 1'b0;
    else if (ring_load_s)               event_r <= 1'b1;
    else if (stat_wr_s && writedata[2]) event_r <= 1'b0;
    else                                event_r <= event_r;
  end

  // Snooze target captured from the current time when snooze is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snz_min_r  <= 6'd0;
      snz_hour_r <= 5'd0;
    end else if (snooze_s) begin
      {snz_hour_r, snz_min_r} <= add_minutes(hour_s, min_s, 6'(SNOOZE_MIN));
    end
  end

  // Alarm and control registers with range checking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_min_r  <= 6'd0;
      alarm_hour_r <= 5'd0;
      control_r    <= 2'd0;
    end else begin
      if (wr_s && (address == ADDR_ALARM_MIN) && min_ok_s)   alarm_min_r  <= writedata[5:0];
      if (wr_s && (address == ADDR_ALARM_HOUR) && hour_ok_s) alarm_hour_r <= writedata[4:0];
      if (ctrl_wr_s) control_r <= writedata[1:0];
    end
  end

  // Read multiplexer; unused bits and address 7 read zero.
  always_comb begin
    case (address)
      ADDR_SEC:        rd_mux_s = {10'd0, sec_s};
      ADDR_MIN:        rd_mux_s = {10'd0, min_s};
      ADDR_HOUR:       rd_mux_s = {11'd0, hour_s};
      ADDR_ALARM_MIN:  rd_mux_s = {10'd0, alarm_min_r};
      ADDR_ALARM_HOUR: rd_mux_s = {11'd0, alarm_hour_r};
      ADDR_CONTROL:    rd_mux_s = {14'd0, control_r};
      ADDR_STATUS:     rd_mux_s = {13'd0, event_r, (state_r == ST_SNOOZED), (state_r == ST_RINGING)};
      default:         rd_mux_s = 16'd0;
    endcase
  end

  // Registered read data, refreshed on every selected cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           readdata <= 16'd0;
    else if (chipselect) readdata <= rd_mux_s;
    else                 readdata <= readdata;
  end

  assign irq    = event_r && control_r[1];
  assign buzzer = (state_r == ST_RINGING);

endmodule

// File: tb/tb_reloj_alarm.sv
// Directed self-checking bench for reloj_alarm: reset, rollover, alarm,
// snooze, collisions, illegal writes and reset while ringing.
module tb_reloj_alarm;
  import reloj_alarm_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'd0;
  logic [15:0] readdata;
  logic        irq;
  logic        buzzer;

  int checks = 0;
  int fails  = 0;

  reloj_alarm dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .buzzer     (buzzer)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  task automatic do_write(input logic [2:0] a, input logic [15:0] d, input logic with_tick);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d; tick = with_tick;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; tick = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0;
    d = readdata;
  endtask

  task automatic pulse_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // Alarm at ah:am, time th:tm:59, both enables on, then one tick to start ringing.
  task automatic setup_ring(input logic [15:0] ah, input logic [15:0] am,
                            input logic [15:0] th, input logic [15:0] tm);
    do_write(ADDR_ALARM_MIN, am, 1'b0);
    do_write(ADDR_ALARM_HOUR, ah, 1'b0);
    do_write(ADDR_HOUR, th, 1'b0);
    do_write(ADDR_MIN, tm, 1'b0);
    do_write(ADDR_SEC, 16'd59, 1'b0);
    do_write(ADDR_CONTROL, 16'd3, 1'b0);
    pulse_tick();
  endtask

  task automatic test_reset();
    logic [15:0] v;
    checks++; if (buzzer !== 1'b0 || irq !== 1'b0 || readdata !== 16'd0) begin
      fails++; $display("FAIL reset_outputs got buzzer=%0b irq=%0b rd=%0h want 0 0 0", buzzer, irq, readdata);
    end
    for (int a = 0; a < 8; a++) begin
      do_read(3'(a), v);
      checks++; if (v !== 16'd0) begin
        fails++; $display("FAIL reset_reg%0d got %0h want 0", a, v);
      end
    end
  endtask

  task automatic test_rollover();
    logic [15:0] v;
    apply_reset();
    do_write(ADDR_HOUR, 16'd23, 1'b0);
    do_write(ADDR_MIN, 16'd59, 1'b0);
    do_write(ADDR_SEC, 16'd59, 1'b0);
    pulse_tick();
    do_read(ADDR_SEC, v);
    checks++; if (v !== 16'd0) begin fails++; $display("FAIL roll_sec got %0d want 0", v); end
    do_read(ADDR_MIN, v);
    checks++; if (v !== 16'd0) begin fails++; $display("FAIL roll_min got %0d want 0", v); end
    do_read(ADDR_HOUR, v);
    checks++; if (v !== 16'd0) begin fails++; $display("FAIL roll_hour got %0d want 0", v); end
  endtask

  task automatic test_alarm();
    logic [15:0] v;
    apply_reset();
    setup_ring(16'd7, 16'd30, 16'd7, 16'd29);
    checks++; if (buzzer !== 1'b1 || irq !== 1'b1) begin
      fails++; $display("FAIL alarm_start got buzzer=%0b irq=%0b want 1 1", buzzer, irq);
    end
    repeat (59) pulse_tick();
    checks++; if (buzzer !== 1'b1) begin fails++; $display("FAIL alarm_59 got buzzer=%0b want 1", buzzer); end
    pulse_tick();
    checks++; if (buzzer !== 1'b0) begin fails++; $display("FAIL alarm_60 got buzzer=%0b want 0", buzzer); end
    do_read(ADDR_MIN, v);
    checks++; if (v !== 16'd31) begin fails++; $display("FAIL alarm_min_after got %0d want 31", v); end
    do_read(ADDR_STATUS, v);
    checks++; if (v !== 16'h4) begin fails++; $display("FAIL alarm_status got %0h want 4", v); end
    do_write(ADDR_STATUS, 16'h4, 1'b0);
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL alarm_irq_clear got %0b want 0", irq); end
  endtask

  task automatic test_snooze();
    logic [15:0] v;
    apply_reset();
    setup_ring(16'd7, 16'd30, 16'd7, 16'd29);
    do_write(ADDR_STATUS, 16'h2, 1'b0);
    checks++; if (buzzer !== 1'b0) begin fails++; $display("FAIL snooze_quiet got %0b want 0", buzzer); end
    do_read(ADDR_STATUS, v);
    checks++; if (v !== 16'h6) begin fails++; $display("FAIL snooze_status got %0h want 6", v); end
    do_write(ADDR_MIN, 16'd34, 1'b0);
    do_write(ADDR_SEC, 16'd59, 1'b0);
    checks++; if (buzzer !== 1'b0) begin fails++; $display("FAIL snooze_early got %0b want 0", buzzer); end
    pulse_tick();
    checks++; if (buzzer !== 1'b1) begin fails++; $display("FAIL snooze_ring got %0b want 1", buzzer); end
    // Snooze across midnight: 23:58 + 5 -> 00:03.
    apply_reset();
    setup_ring(16'd23, 16'd58, 16'd23, 16'd57);
    do_write(ADDR_STATUS, 16'h2, 1'b0);
    do_write(ADDR_HOUR, 16'd0, 1'b0);
    do_write(ADDR_MIN, 16'd2, 1'b0);
    do_write(ADDR_SEC, 16'd59, 1'b0);
    checks++; if (buzzer !== 1'b0) begin fails++; $display("FAIL snooze_wrap_early got %0b want 0", buzzer); end
    pulse_tick();
    checks++; if (buzzer !== 1'b1) begin fails++; $display("FAIL snooze_wrap_ring got %0b want 1", buzzer); end
  endtask

  task automatic test_collisions();
    logic [15:0] v;
    apply_reset();
    do_write(ADDR_SEC, 16'd5, 1'b0);
    do_write(ADDR_SEC, 16'd10, 1'b1);
    do_read(ADDR_SEC, v);
    checks++; if (v !== 16'd10) begin fails++; $display("FAIL coll_sec got %0d want 10", v); end
    do_write(ADDR_MIN, 16'd3, 1'b0);
    do_write(ADDR_SEC, 16'd59, 1'b0);
    do_write(ADDR_SEC, 16'd10, 1'b1);
    do_read(ADDR_SEC, v);
    checks++; if (v !== 16'd10) begin fails++; $display("FAIL coll_sec59 got %0d want 10", v); end
    do_read(ADDR_MIN, v);
    checks++; if (v !== 16'd3) begin fails++; $display("FAIL coll_no_carry got %0d want 3", v); end
    setup_ring(16'd7, 16'd30, 16'd7, 16'd29);
    do_write(ADDR_STATUS, 16'h3, 1'b0);
    checks++; if (buzzer !== 1'b0) begin fails++; $display("FAIL coll_dismiss got %0b want 0", buzzer); end
    do_read(ADDR_STATUS, v);
    checks++; if (v !== 16'h4) begin fails++; $display("FAIL coll_status got %0h want 4", v); end
  endtask

  task automatic test_illegal();
    logic [15:0] v;
    apply_reset();
    do_write(ADDR_MIN, 16'd5, 1'b0);
    do_write(ADDR_MIN, 16'd60, 1'b0);
    do_read(ADDR_MIN, v);
    checks++; if (v !== 16'd5) begin fails++; $display("FAIL illegal_min got %0d want 5", v); end
    do_write(ADDR_HOUR, 16'd3, 1'b0);
    do_write(ADDR_HOUR, 16'd24, 1'b0);
    do_read(ADDR_HOUR, v);
    checks++; if (v !== 16'd3) begin fails++; $display("FAIL illegal_hour got %0d want 3", v); end
    do_write(ADDR_ALARM_HOUR, 16'd24, 1'b0);
    do_read(ADDR_ALARM_HOUR, v);
    checks++; if (v !== 16'd0) begin fails++; $display("FAIL illegal_ahour got %0d want 0", v); end
    setup_ring(16'd7, 16'd30, 16'd7, 16'd29);
    checks++; if (buzzer !== 1'b1) begin fails++; $display("FAIL illegal_ring got %0b want 1", buzzer); end
    do_write(ADDR_CONTROL, 16'd0, 1'b0);
    checks++; if (buzzer !== 1'b0) begin fails++; $display("FAIL disable_stop got %0b want 0", buzzer); end
    do_read(ADDR_STATUS, v);
    checks++; if (v !== 16'h4) begin fails++; $display("FAIL disable_status got %0h want 4", v); end
  endtask

  task automatic test_reset_ringing();
    logic [15:0] v;
    apply_reset();
    setup_ring(16'd12, 16'd0, 16'd11, 16'd59);
    repeat (5) pulse_tick();
    do_read(ADDR_SEC, v);
    checks++; if (v !== 16'd5 || buzzer !== 1'b1) begin
      fails++; $display("FAIL rr_pre got sec=%0d buzzer=%0b want 5 1", v, buzzer);
    end
    @(negedge clk); reset = 1'b1;
    #1;
    checks++; if (buzzer !== 1'b0 || irq !== 1'b0 || readdata !== 16'd0) begin
      fails++; $display("FAIL rr_outputs got buzzer=%0b irq=%0b rd=%0h want 0 0 0", buzzer, irq, readdata);
    end
    @(negedge clk); reset = 1'b0;
    do_read(ADDR_SEC, v);
    checks++; if (v !== 16'd0) begin fails++; $display("FAIL rr_sec got %0d want 0", v); end
    do_read(ADDR_MIN, v);
    checks++; if (v !== 16'd0) begin fails++; $display("FAIL rr_min got %0d want 0", v); end
    do_read(ADDR_HOUR, v);
    checks++; if (v !== 16'd0) begin fails++; $display("FAIL rr_hour got %0d want 0", v); end
    do_read(ADDR_STATUS, v);
    checks++; if (v !== 16'd0) begin fails++; $display("FAIL rr_status got %0h want 0", v); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_rollover();
    test_alarm();
    test_snooze();
    test_collisions();
    test_illegal();
    test_reset_ringing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
